zxn_audio_conditioner: RTL
==========================

# zxn_audio_conditioner

Output audio stage between the core's 12-bit unsigned stereo outputs (`aud_l`/`aud_r`) and the framework `AUDIO_L`/`AUDIO_R` ports. It expands samples to 16 bits and low-pass filters them at `clk_sys` rate. It resamples the result onto a fractional-divided 48 kHz strobe and applies a pop-free gain ramp on reset and mute. An optional DC blocker re-centres the output.

## Interface
Parameters:
- `CLK_RATE`, 28000000: `clk_sys` frequency in Hz.
- `SAMPLE_RATE`, 48000: output strobe rate in Hz; must be less than `CLK_RATE`.
- `LPF_SHIFT`, 4: IIR low-pass coefficient, 2^-LPF_SHIFT.

Ports:
- `clk_sys`, in, 1: system clock.
- `RESET`, in, 1: synchronous, active-high reset.
- `aud_l_in`, in, 12: left sample, unsigned.
- `aud_r_in`, in, 12: right sample, unsigned.
- `mute`, in, 1: level signal; 1 fades the output to silence.
- `audio_l`, out, 16: conditioned left sample, unsigned.
- `audio_r`, out, 16: conditioned right sample, unsigned.
- `sample_stb`, out, 1: one-cycle pulse when `audio_l`/`audio_r` update.
- `ramp_done`, out, 1: gain is at unity.

## Operation
- **Expansion:** x16 = {x[11:0], x[11:8]}. 0x000 maps to 0x0000, 0x800 to 0x8008, 0xFFF to 0xFFFF.
- **Low-pass filter:** one accumulator per channel, acc[16+LPF_SHIFT-1:0].
  - Update every cycle: acc <= acc + x16 - acc[top 16].
  - Filtered value f = acc[top 16].
  - A constant input converges exactly to f = x16. No overflow is possible.
- **Strobe generator:** 32-bit phase register.
  - Each cycle, form p = phase + SAMPLE_RATE.
  - If p >= CLK_RATE: phase <= p - CLK_RATE and strobe fires. Otherwise phase <= p.
  - Over any CLK_RATE-cycle window there are exactly SAMPLE_RATE strobes.
  - With defaults, strobe intervals are only 583 or 584 cycles.
- **Gain ramp:** 9-bit g, range 0..256, changes only on strobe.
  - mute=0 and g<256: g+1.
  - mute=1 and g>0: g-1.
  - Otherwise g holds.
  - Full ramp is 256 strobes, about 5.33 ms at defaults.
- **Output:** on strobe, s = (f * g) >> 8, computed with a 25-bit product. s feeds the output path (DC blocker, if compiled in) and is registered into `audio_l`/`audio_r`.
- `ramp_done` = (g == 256), registered.
- **Mute toggling mid-ramp:** direction reverses on the next strobe with no jump in g.
- **Channels:** left and right are processed identically and updated in the same cycle.

## Timing
- **Reset values:**
  - acc = 0, phase = 0, g = 0.
  - `audio_l`/`audio_r` = 0x0000, or 0x8000 when the DC blocker is compiled in.
  - `sample_stb` = 0, `ramp_done` = 0.
- **Reset wins:** `RESET` overrides every other event in the same cycle. Reset mid-operation discards in-flight state; the first strobe after release always follows release by 584 cycles at defaults.
- **Input latency:** inputs are sampled every cycle with no input register. The filter contributes a time constant of 2^LPF_SHIFT cycles.
- **Output alignment:** `sample_stb` and the new output values are asserted in the same cycle, one cycle after the phase compare.
  - The output uses f and g as they stood in the compare cycle, i.e. pre-update g.
  - Outputs hold between strobes.
- **Stability:** `mute` is sampled only on strobe cycles.

## Configuration
- **`ZXN_AUDIO_DCBLOCK_EN` defined:** per-channel DC tracker dc[25:0], updated on strobe only.
  - dc <= dc + s - dc[25:10]; the tracked DC level is dc[25:10].
  - Output = saturate(0x8000 + s - dc[25:10]) to the range 0x0000..0xFFFF.
  - Reset output is 0x8000.
- **Not defined:** output = s, and the DC logic is absent.

## Test plan
- **Strobe cadence:** run 28,000,000 cycles after reset release -> exactly 48,000 `sample_stb` pulses; first pulse 584 cycles after release; every interval is 583 or 584.
- **Ramp-up:** constant input 0x800 both channels, mute=0 -> `ramp_done`=1 after the 257th strobe; output 0x8008 from then on; outputs strictly non-decreasing during the ramp.
- **Full-scale input:** constant 0xFFF after ramp -> output 0xFFFF; constant 0x000 -> output 0x0000; no wrap.
- **Mute fade:** assert mute after ramp_done with input 0xFFF -> `ramp_done` drops on the next strobe; output reaches 0x0000 256 strobes later; deasserting mute at g=128 ramps back up without a step.
- **Reset mid-ramp:** pulse `RESET` for 1 cycle at g=100 -> next cycle all outputs at reset values, g=0; next strobe 584 cycles later.
- **DC blocker (macro defined):** step input 0x000 -> 0xFFF after ramp -> output jumps toward 0xFFFF (saturated), then decays monotonically toward 0x8000; it stays within 0x8000±0x0100 after 8192 strobes.

Source files
------------

// File: rtl/zxn_audio_conditioner.sv
// Output audio stage: 12->16 bit expansion, IIR low-pass, fractional 48 kHz resampling
// and pop-free gain ramp. Define ZXN_AUDIO_DCBLOCK_EN to compile in the DC blocker.
module zxn_audio_conditioner #(
    parameter int CLK_RATE    = 28000000,
    parameter int SAMPLE_RATE = 48000,
    parameter int LPF_SHIFT   = 4
) (
    input  logic        clk_sys,
    input  logic        RESET,
    input  logic [11:0] aud_l_in,
    input  logic [11:0] aud_r_in,
    input  logic        mute,
    output logic [15:0] audio_l,
    output logic [15:0] audio_r,
    output logic        sample_stb,
    output logic        ramp_done
);

    localparam int AW = 16 + LPF_SHIFT;
`ifdef ZXN_AUDIO_DCBLOCK_EN
    localparam logic [15:0] OUT_RST = 16'h8000;
`else
    localparam logic [15:0] OUT_RST = 16'h0000;
`endif

    logic [15:0]   x16_l, x16_r;
    logic [AW-1:0] acc_l, acc_r;
    logic [15:0]   f_l, f_r;
    logic [31:0]   phase;
    logic [32:0]   phase_sum;
    logic          hit;
    logic [8:0]    g, g_next;
    logic [24:0]   prod_l, prod_r;
    logic [15:0]   s_l, s_r;
    logic [15:0]   out_l, out_r;

    assign x16_l = {aud_l_in, aud_l_in[11:8]};
    assign x16_r = {aud_r_in, aud_r_in[11:8]};
    assign f_l   = acc_l[AW-1 -: 16];
    assign f_r   = acc_r[AW-1 -: 16];

    // Fractional divider: the phase wraps exactly SAMPLE_RATE times per CLK_RATE cycles.
    assign phase_sum = {1'b0, phase} + 33'(SAMPLE_RATE);
    assign hit       = (phase_sum >= 33'(CLK_RATE));

    always_comb begin
        g_next = g;
        if (!mute && g != 9'd256)
            g_next = g + 9'd1;
        else if (mute && g != 9'd0)
            g_next = g - 9'd1;
    end

    assign prod_l = 25'(f_l) * 25'(g);
    assign prod_r = 25'(f_r) * 25'(g);
    assign s_l    = 16'(prod_l >> 8);
    assign s_r    = 16'(prod_r >> 8);

`ifdef ZXN_AUDIO_DCBLOCK_EN
    logic [25:0] dc_l, dc_r;

    // Re-centre around mid-scale, clamping instead of wrapping on large steps.
    function automatic logic [15:0] dc_out(input logic [15:0] s, input logic [25:0] dc);
        logic signed [17:0] v;
        v = 18'sd32768 + $signed({2'b00, s}) - $signed({2'b00, dc[25:10]});
        if (v < 18'sd0)
            return 16'h0000;
        else if (v > 18'sd65535)
            return 16'hFFFF;
        else
            return v[15:0];
    endfunction

    assign out_l = dc_out(s_l, dc_l);
    assign out_r = dc_out(s_r, dc_r);

    always_ff @(posedge clk_sys) begin
        if (RESET) begin
            dc_l <= '0;
            dc_r <= '0;
        end else if (hit) begin
            dc_l <= dc_l + 26'(s_l) - 26'(dc_l[25:10]);
            dc_r <= dc_r + 26'(s_r) - 26'(dc_r[25:10]);
        end
    end
`else
    assign out_l = s_l;
    assign out_r = s_r;
`endif

    always_ff @(posedge clk_sys) begin
        if (RESET) begin
            acc_l      <= '0;
            acc_r      <= '0;
            phase      <= '0;
            g          <= '0;
            audio_l    <= OUT_RST;
            audio_r    <= OUT_RST;
            sample_stb <= 1'b0;
            ramp_done  <= 1'b0;
        end else begin
            // Modular in AW bits: the settled accumulator always fits, so wrap of the
            // intermediate sum cancels out.
            acc_l      <= acc_l + AW'(x16_l) - AW'(f_l);
            acc_r      <= acc_r + AW'(x16_r) - AW'(f_r);
            phase      <= hit ? 32'(phase_sum - 33'(CLK_RATE)) : phase_sum[31:0];
            sample_stb <= hit;
            ramp_done  <= (g == 9'd256);
            if (hit) begin
                g       <= g_next;
                audio_l <= out_l;
                audio_r <= out_r;
            end
        end
    end

endmodule
